// File: rtl/miner_job_loader.sv
// AXI-lite master that loads one mining job into axi_miner, starts it, polls
// status until the hash is ready, reads the hash back and presents the result.
module miner_job_loader #(
   parameter int unsigned POLL_GAP  = 8,
   parameter int unsigned MAX_POLLS = 1024
) (
   input  logic         M_AXI_ACLK,
   input  logic         M_AXI_ARESETN,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [639:0] job_header,
   input  logic [255:0] job_target,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [255:0] res_hash,
   output logic         res_found,
   output logic         res_timeout,
   output logic         res_error,
   output logic [7:0]   M_AXI_AWADDR,
   output logic         M_AXI_AWVALID,
   input  logic         M_AXI_AWREADY,
   output logic [31:0]  M_AXI_WDATA,
   output logic [3:0]   M_AXI_WSTRB,
   output logic         M_AXI_WVALID,
   input  logic         M_AXI_WREADY,
   input  logic [1:0]   M_AXI_BRESP,
   input  logic         M_AXI_BVALID,
   output logic         M_AXI_BREADY,
   output logic [7:0]   M_AXI_ARADDR,
   output logic         M_AXI_ARVALID,
   input  logic         M_AXI_ARREADY,
   input  logic [31:0]  M_AXI_RDATA,
   input  logic [1:0]   M_AXI_RRESP,
   input  logic         M_AXI_RVALID,
   output logic         M_AXI_RREADY
);

   localparam int unsigned PW = $clog2(MAX_POLLS + 1);
   localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   typedef enum logic [3:0] {
      IDLE, WR_ADDR_DATA, WR_RESP, POLL_RD_ADDR, POLL_RD_DATA,
      POLL_WAIT, HASH_RD_ADDR, HASH_RD_DATA, RESULT
   } state_t;

   state_t         state;
   logic [639:0]   header_r;
   logic [255:0]   target_r;
   logic [4:0]     wr_idx;
   logic [2:0]     hash_idx;
   logic [PW-1:0]  poll_cnt;
   logic [GW-1:0]  gap_cnt;

   assign M_AXI_WSTRB = 4'hF;

   // Write index 0..19 header, 20..27 target, 28 start bit.
   function automatic logic [7:0] wr_addr(input logic [4:0] i);
      if (i < 5'd20) return {1'b0, i, 2'b00};
      if (i < 5'd28) return 8'h58 + {1'b0, i - 5'd20, 2'b00};
      return 8'h50;
   endfunction

   function automatic logic [31:0] wr_data(input logic [4:0] i,
                                           input logic [639:0] h,
                                           input logic [255:0] t);
      logic [639:0] hs;
      logic [255:0] ts;
      hs = h << {i, 5'b0};
      ts = t << {i - 5'd20, 5'b0};
      if (i < 5'd20) return hs[639:608];
      if (i < 5'd28) return ts[255:224];
      return 32'h0000_0001;
   endfunction

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         state         <= IDLE;
         header_r      <= '0;
         target_r      <= '0;
         wr_idx        <= '0;
         hash_idx      <= '0;
         poll_cnt      <= '0;
         gap_cnt       <= '0;
         job_ready     <= 1'b1;
         res_valid     <= 1'b0;
         res_hash      <= '0;
         res_found     <= 1'b0;
         res_timeout   <= 1'b0;
         res_error     <= 1'b0;
         M_AXI_AWADDR  <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (job_valid && job_ready) begin
               header_r      <= job_header;
               target_r      <= job_target;
               job_ready     <= 1'b0;
               res_hash      <= '0;
               res_found     <= 1'b0;
               res_timeout   <= 1'b0;
               res_error     <= 1'b0;
               poll_cnt      <= '0;
               wr_idx        <= '0;
               M_AXI_AWADDR  <= 8'h00;
               M_AXI_WDATA   <= job_header[639:608];
               M_AXI_AWVALID <= 1'b1;
               M_AXI_WVALID  <= 1'b1;
               state         <= WR_ADDR_DATA;
            end
            // A channel whose VALID has already dropped has completed its beat.
            WR_ADDR_DATA: begin
               if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
               if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
               if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                  M_AXI_BREADY <= 1'b1;
                  state        <= WR_RESP;
               end
            end
            WR_RESP: if (M_AXI_BVALID) begin
               M_AXI_BREADY <= 1'b0;
               if (M_AXI_BRESP != 2'b00) res_error <= 1'b1;
               if (wr_idx == 5'd28) begin
                  M_AXI_ARADDR  <= 8'h54;
                  M_AXI_ARVALID <= 1'b1;
                  state         <= POLL_RD_ADDR;
               end else begin
                  wr_idx        <= wr_idx + 5'd1;
                  M_AXI_AWADDR  <= wr_addr(wr_idx + 5'd1);
                  M_AXI_WDATA   <= wr_data(wr_idx + 5'd1, header_r, target_r);
                  M_AXI_AWVALID <= 1'b1;
                  M_AXI_WVALID  <= 1'b1;
                  state         <= WR_ADDR_DATA;
               end
            end
            POLL_RD_ADDR: if (M_AXI_ARREADY) begin
               M_AXI_ARVALID <= 1'b0;
               M_AXI_RREADY  <= 1'b1;
               state         <= POLL_RD_DATA;
            end
            POLL_RD_DATA: if (M_AXI_RVALID) begin
               M_AXI_RREADY <= 1'b0;
               if (M_AXI_RRESP != 2'b00) res_error <= 1'b1;
               if (M_AXI_RDATA[2]) begin
                  res_found     <= M_AXI_RDATA[3];
                  hash_idx      <= '0;
                  M_AXI_ARADDR  <= 8'h78;
                  M_AXI_ARVALID <= 1'b1;
                  state         <= HASH_RD_ADDR;
               end else if (poll_cnt + PW'(1) == PW'(MAX_POLLS)) begin
                  poll_cnt    <= poll_cnt + PW'(1);
                  res_timeout <= 1'b1;
                  res_valid   <= 1'b1;
                  state       <= RESULT;
               end else begin
                  poll_cnt <= poll_cnt + PW'(1);
                  if (POLL_GAP == 0) begin
                     M_AXI_ARVALID <= 1'b1;
                     state         <= POLL_RD_ADDR;
                  end else begin
                     gap_cnt <= GW'(POLL_GAP - 1);
                     state   <= POLL_WAIT;
                  end
               end
            end
            POLL_WAIT: begin
               if (gap_cnt == '0) begin
                  M_AXI_ARVALID <= 1'b1;
                  state         <= POLL_RD_ADDR;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            HASH_RD_ADDR: if (M_AXI_ARREADY) begin
               M_AXI_ARVALID <= 1'b0;
               M_AXI_RREADY  <= 1'b1;
               state         <= HASH_RD_DATA;
            end
            // Words shift in from the bottom, so word 0 ends at the top slice.
            HASH_RD_DATA: if (M_AXI_RVALID) begin
               M_AXI_RREADY <= 1'b0;
               if (M_AXI_RRESP != 2'b00) res_error <= 1'b1;
               res_hash <= {res_hash[223:0], M_AXI_RDATA};
               if (hash_idx == 3'd7) begin
                  res_valid <= 1'b1;
                  state     <= RESULT;
               end else begin
                  hash_idx      <= hash_idx + 3'd1;
                  M_AXI_ARADDR  <= M_AXI_ARADDR + 8'd4;
                  M_AXI_ARVALID <= 1'b1;
                  state         <= HASH_RD_ADDR;
               end
            end
            RESULT: if (res_ready) begin
               res_valid <= 1'b0;
               job_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_miner_job_loader.sv
// Directed bench for miner_job_loader against a behavioural axi_miner slave.
module tb_miner_job_loader;

   localparam logic [255:0] HASH =
      256'h4be7570e8f70eb093640c8468274ba759745a7aa2b7d25ab1e0421b259845014;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstn, job_valid, job_ready, res_valid, res_ready;
   logic [639:0] job_header;
   logic [255:0] job_target, res_hash;
   logic         res_found, res_timeout, res_error;
   logic [7:0]   awaddr, araddr;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;

   miner_job_loader #(.POLL_GAP(2), .MAX_POLLS(4)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_header(job_header), .job_target(job_target),
      .res_valid(res_valid), .res_ready(res_ready), .res_hash(res_hash),
      .res_found(res_found), .res_timeout(res_timeout), .res_error(res_error),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
      .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
      .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   // Slave configuration, written only by the stimulus process.
   int         delay_mode, status_mode, stat_base;
   logic [7:0] err_addr;

   // Slave state and logs.
   int          cyc = 0, ca, cw, n_wr = 0, n_stat = 0, n_hash = 0;
   int          aw_stab = 0, w_stab = 0, proto_err = 0;
   logic        aw_got, w_got, aw_pend, w_pend;
   logic [7:0]  cur_addr, aw_prev;
   logic [31:0] cur_data, w_prev;
   logic [7:0]  wlog_a [0:511];
   logic [31:0] wlog_d [0:511];
   int          stat_cyc [0:255];

   int da, dw;
   assign da = (delay_mode == 1 && n_wr % 2 == 0) ? 3 : 0;
   assign dw = (delay_mode == 1 && n_wr % 2 == 1) ? 3 : 0;
   assign awready = awvalid && !aw_got && (ca >= da);
   assign wready  = wvalid && !w_got && (cw >= dw);
   assign arready = arvalid && !rvalid;
   assign rresp   = 2'b00;

   function automatic logic [31:0] hword(input logic [7:0] a);
      logic [255:0] t;
      t = HASH << (32 * ((int'(a) - 'h78) / 4));
      return t[255:224];
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rstn) begin
         aw_got <= 1'b0; w_got <= 1'b0; aw_pend <= 1'b0; w_pend <= 1'b0;
         ca <= 0; cw <= 0; bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0;
      end else begin
         if (aw_pend && (!awvalid || awaddr != aw_prev)) aw_stab <= aw_stab + 1;
         if ((w_pend && (!wvalid || wdata != w_prev)) || (wvalid && wstrb != 4'hF)) w_stab <= w_stab + 1;
         aw_pend <= awvalid && !awready;
         w_pend  <= wvalid && !wready;
         aw_prev <= awaddr;
         w_prev  <= wdata;
         if (awvalid && arvalid) proto_err <= proto_err + 1;
         if (awvalid && !aw_got) begin
            if (awready) begin aw_got <= 1'b1; cur_addr <= awaddr; end
            else ca <= ca + 1;
         end
         if (wvalid && !w_got) begin
            if (wready) begin w_got <= 1'b1; cur_data <= wdata; end
            else cw <= cw + 1;
         end
         if (aw_got && w_got && !bvalid) begin
            bvalid <= 1'b1;
            bresp  <= (cur_addr == err_addr) ? 2'b10 : 2'b00;
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; ca <= 0; cw <= 0;
            if (n_wr < 512) begin wlog_a[n_wr] <= cur_addr; wlog_d[n_wr] <= cur_data; end
            n_wr <= n_wr + 1;
         end
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            if (araddr == 8'h54) begin
               if (n_stat < 256) stat_cyc[n_stat] <= cyc;
               n_stat <= n_stat + 1;
               rdata <= (status_mode == 1 || n_stat == stat_base) ? 32'h0 :
                        (status_mode == 2) ? 32'h4 : 32'hC;
            end else if (araddr >= 8'h78 && araddr <= 8'h94) begin
               n_hash <= n_hash + 1;
               rdata  <= hword(araddr);
            end else begin
               proto_err <= proto_err + 1;
               rdata     <= 32'hDEAD_0000;
            end
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   int n_vec = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [639:0] mk_hdr(input logic [31:0] seed);
      logic [639:0] h = '0;
      for (int i = 0; i < 20; i++) h = {h[607:0], seed + 32'h0101_0101 * i};
      return h;
   endfunction

   function automatic logic [255:0] mk_tgt(input logic [31:0] seed);
      logic [255:0] t = '0;
      for (int i = 0; i < 8; i++) t = {t[223:0], seed ^ (32'h1111_0000 * i)};
      return t;
   endfunction

   typedef struct {
      string        name;
      logic [639:0] hdr;
      logic [255:0] tgt;
      int           smode, dmode;
      logic [7:0]   eaddr;
      logic [255:0] ehash;
      logic         efound, etimeout, eerror;
      int           estat, ehrd;
   } vec_t;

   vec_t vecs [6];

   task automatic run_job(input vec_t v, input int hold);
      int wb, hb, pb, bad;
      logic ok;
      logic [255:0] h0;
      logic [639:0] hs;
      logic [255:0] ts;
      logic [7:0]   ea;
      logic [31:0]  ed;
      delay_mode = v.dmode; status_mode = v.smode; err_addr = v.eaddr;
      wb = n_wr; hb = n_hash; stat_base = n_stat; pb = aw_stab + w_stab + proto_err;
      @(negedge clk);
      job_header = v.hdr; job_target = v.tgt; job_valid = 1'b1;
      for (int i = 0; i < 50 && !job_ready; i++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
      chk({v.name, ".job_ready_low"}, job_ready, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (res_valid) begin ok = 1'b1; break; end
      end
      chk({v.name, ".res_valid_seen"}, ok, 1'b1);
      chk({v.name, ".hash"}, res_hash, v.ehash);
      chk({v.name, ".flags"}, {res_found, res_timeout, res_error}, {v.efound, v.etimeout, v.eerror});
      chk({v.name, ".n_writes"}, n_wr - wb, 29);
      bad = 0;
      for (int k = 0; k < 29; k++) begin
         hs = v.hdr << (32 * k);
         ts = v.tgt << (32 * (k - 20));
         if (k < 20)      begin ea = 8'(4 * k);             ed = hs[639:608]; end
         else if (k < 28) begin ea = 8'(8'h58 + 4 * (k - 20)); ed = ts[255:224]; end
         else             begin ea = 8'h50;                 ed = 32'h1; end
         if (wb + k < 512 && (wlog_a[wb + k] !== ea || wlog_d[wb + k] !== ed)) bad++;
      end
      chk({v.name, ".wr_seq_bad_beats"}, bad, 0);
      chk({v.name, ".status_reads"}, n_stat - stat_base, v.estat);
      chk({v.name, ".hash_reads"}, n_hash - hb, v.ehrd);
      chk({v.name, ".protocol_errs"}, aw_stab + w_stab + proto_err - pb, 0);
      bad = 0;
      for (int k = stat_base + 1; k < n_stat && k < 256; k++)
         if (stat_cyc[k] - stat_cyc[k - 1] < 4) bad++;
      chk({v.name, ".poll_spacing_bad"}, bad, 0);
      if (hold > 0) begin
         h0 = res_hash; bad = 0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!res_valid || res_hash !== h0 || job_ready ||
                awvalid || wvalid || bready || arvalid || rready) bad++;
         end
         chk({v.name, ".hold_unstable"}, bad, 0);
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({v.name, ".res_handshake"}, {res_valid, job_ready}, 2'b01);
      res_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
      job_header = '0; job_target = '0;
      delay_mode = 0; status_mode = 0; err_addr = 8'hFF; stat_base = 0;

      vecs[0] = '{"zero_hdr", '0, '1, 0, 0, 8'hFF, HASH, 1'b1, 1'b0, 1'b0, 2, 8};
      vecs[1] = '{"alt_delay", mk_hdr(32'h1234_5678), mk_tgt(32'hCAFE_F00D), 0, 1, 8'hFF,
                  HASH, 1'b1, 1'b0, 1'b0, 2, 8};
      vecs[2] = '{"timeout", mk_hdr(32'hA5A5_0000), mk_tgt(32'h0F0F_0F0F), 1, 0, 8'hFF,
                  '0, 1'b0, 1'b1, 1'b0, 4, 0};
      vecs[3] = '{"bresp_err", mk_hdr(32'h0000_1000), mk_tgt(32'h8000_0001), 0, 0, 8'h60,
                  HASH, 1'b1, 1'b0, 1'b1, 2, 8};
      vecs[4] = '{"clean_after_err", mk_hdr(32'h7777_0001), mk_tgt(32'h0000_FFFF), 0, 1, 8'hFF,
                  HASH, 1'b1, 1'b0, 1'b0, 2, 8};
      vecs[5] = '{"not_found", mk_hdr(32'h3C3C_3C3C), mk_tgt(32'h1234_0000), 2, 0, 8'hFF,
                  HASH, 1'b0, 1'b0, 1'b0, 2, 8};

      repeat (3) @(negedge clk);
      chk("reset_ctrl", {job_ready, res_valid, awvalid, wvalid, bready, arvalid, rready,
                         res_found, res_timeout, res_error}, 10'b10_0000_0000);
      chk("reset_data", {awaddr, araddr, wdata}, '0);
      chk("reset_hash", res_hash, '0);
      rstn = 1'b1;

      for (int i = 0; i < 6; i++) run_job(vecs[i], 0);

      // Result held back by the consumer.
      run_job(vecs[1], 10);

      // Reset while header word 7 is in flight, then a fresh job.
      delay_mode = 1; status_mode = 0; err_addr = 8'hFF;
      @(negedge clk);
      job_header = mk_hdr(32'h5555_AAAA); job_target = '1; job_valid = 1'b1;
      for (int i = 0; i < 50 && !job_ready; i++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 500; i++) begin
            if (awvalid && awaddr == 8'h1C) begin seen = 1'b1; break; end
            @(negedge clk);
         end
         chk("rst_word7_reached", seen, 1'b1);
      end
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_ctrl", {awvalid, wvalid, bready, arvalid, rready, res_valid, job_ready},
          7'b000_0001);
      @(negedge clk);
      rstn = 1'b1;
      run_job(vecs[0], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
